// File: rtl/bram_window_pkg.sv
// Shared types and helpers for the decoded block-RAM window.
//   rmw_state_t : partial-write sequencer states
//   lanes()     : number of byte-enable lanes in a word
//   merge_lanes : lane-wise merge of new data over old data
package bram_window_pkg;

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} rmw_state_t;

  // merge_lanes works on a fixed maximum width so one function serves every
  // instance; callers zero-extend their operands and truncate the result.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_LANES  = 256;

  function automatic int lanes(input int dw, input int lw);
    return dw / lw;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] merge_lanes(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_LANES-1:0]  be,
    input int                    lane_w
  );
    logic [MAX_DATA_W-1:0] m;
    m = old_w;
    for (int b = 0; b < MAX_DATA_W; b++)
      if (be[8'(b / lane_w)]) m[8'(b)] = new_w[8'(b)];
    return m;
  endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous block RAM primitive.
//   clk  : clock
//   addr : word address
//   wr   : write strobe, din stored at addr on the rising edge
//   din  : write data
//   dout : registered read data of addr (old contents on a write cycle)
// Contents are not reset. The pre_fill parameters describe an optional
// initial image and are range-checked here at elaboration.
module bram_sp #(
  parameter int    data_width     = 32,
  parameter int    ram_size       = 64,
  parameter int    pre_fill       = 0,
  parameter int    pre_fill_start = 0,
  parameter string pre_fill_file  = ""
) (
  input  logic                        clk,
  input  logic [$clog2(ram_size)-1:0] addr,
  input  logic                        wr,
  input  logic [data_width-1:0]       din,
  output logic [data_width-1:0]       dout
);

  logic [data_width-1:0] mem [ram_size];

  if (pre_fill != 0 && (pre_fill_start < 0 || pre_fill_start >= ram_size)) begin : g_chk_start
    $error("bram_sp: pre_fill_start outside RAM");
  end
  if (pre_fill != 0 && pre_fill_file == "") begin : g_chk_file
    $error("bram_sp: pre_fill set without pre_fill_file");
  end

  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/bram_window_rmw.sv
// Address-decoded block-RAM window on the CPU bus with per-lane byte
// enables (partial writes done as hardware read-modify-write), selectable
// read latency and a busy handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   addr       : bus word address
//   rd, wr     : requests, taken only when hit=1 and busy=0; wr wins over rd
//   be         : lane enables for wr (all ones = direct write, zero = no-op)
//   din        : write data
//   dout       : read data, held until the next dout_valid
//   dout_valid : one-cycle strobe, read_latency cycles after an accepted rd
//   hit        : addr inside [BaseAddress, EndAddress]
//   busy       : partial write in flight, requests are dropped
module bram_window_rmw
  import bram_window_pkg::*;
#(
  parameter int    BaseAddress    = 0,
  parameter int    EndAddress     = 0,
  parameter int    data_width     = 32,
  parameter int    lane_width     = 8,
  parameter int    address_width  = 16,
  parameter int    ram_size       = 64,
  parameter int    read_latency   = 1,
  parameter int    pre_fill       = 0,
  parameter int    pre_fill_start = 0,
  parameter string pre_fill_file  = ""
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [address_width-1:0]         addr,
  input  logic                             rd,
  input  logic                             wr,
  input  logic [data_width/lane_width-1:0] be,
  input  logic [data_width-1:0]            din,
  output logic [data_width-1:0]            dout,
  output logic                             dout_valid,
  output logic                             hit,
  output logic                             busy
);

  localparam int NL     = lanes(data_width, lane_width);
  localparam int RAM_AW = $clog2(ram_size);
  localparam logic [address_width:0] BASE_X = (address_width+1)'(BaseAddress);
  localparam logic [address_width:0] SPAN_X = (address_width+1)'(EndAddress - BaseAddress);

  if (EndAddress - BaseAddress + 1 > ram_size) begin : g_chk_size
    $error("bram_window_rmw: window larger than ram_size");
  end
  if (read_latency != 1 && read_latency != 2) begin : g_chk_lat
    $error("bram_window_rmw: read_latency must be 1 or 2");
  end
  if (data_width % lane_width != 0 || data_width > MAX_DATA_W) begin : g_chk_width
    $error("bram_window_rmw: bad data_width/lane_width");
  end

  // Decode: one extra bit catches the borrow of addr < BaseAddress, so
  // neither edge can wrap into the window.
  logic [address_width:0] off;
  logic [RAM_AW-1:0]      ram_addr;

  assign off      = {1'b0, addr} - BASE_X;
  assign hit      = ~off[address_width] & (off <= SPAN_X);
  assign ram_addr = off[RAM_AW-1:0];

  rmw_state_t state, st_nx;
  logic acc_rd, acc_wr, full_wr, part_wr;

  assign busy    = (state != IDLE);
  assign acc_wr  = hit & ~busy & wr;
  assign acc_rd  = hit & ~busy & rd & ~wr;
  assign full_wr = acc_wr & (&be);
  assign part_wr = acc_wr & ~(&be) & (|be);

  // RAM port mux
  logic [RAM_AW-1:0]     ram_a;
  logic                  ram_we;
  logic [data_width-1:0] ram_wd, ram_q;

  bram_sp #(
    .data_width(data_width), .ram_size(ram_size), .pre_fill(pre_fill),
    .pre_fill_start(pre_fill_start), .pre_fill_file(pre_fill_file)
  ) u_ram (
    .clk(clk), .addr(ram_a), .wr(ram_we), .din(ram_wd), .dout(ram_q)
  );

  // RMW holding registers; rmw_dat carries din, then the merged word.
  logic [RAM_AW-1:0]     rmw_addr;
  logic [data_width-1:0] rmw_dat, merged;
  logic [NL-1:0]         rmw_be;
  logic                  load_rmw, load_merge;

  always_comb begin
    logic [MAX_DATA_W-1:0] old_x, new_x;
    logic [MAX_LANES-1:0]  be_x;
    old_x = '0;
    new_x = '0;
    be_x  = '0;
    old_x[data_width-1:0] = ram_q;
    new_x[data_width-1:0] = rmw_dat;
    be_x[NL-1:0]          = rmw_be;
    merged = data_width'(merge_lanes(old_x, new_x, be_x, lane_width));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= st_nx;
  end

  always_comb begin
    st_nx      = state;
    ram_a      = ram_addr;
    ram_we     = 1'b0;
    ram_wd     = din;
    load_rmw   = 1'b0;
    load_merge = 1'b0;
    case (state)
      IDLE: begin
        if (full_wr) ram_we = 1'b1;
        else if (part_wr) begin
          load_rmw = 1'b1;   // RAM reads the old word this cycle
          st_nx    = RMW_RD;
        end
      end
      RMW_RD: begin
        ram_a      = rmw_addr;
        load_merge = 1'b1;   // old word is on ram_q now
        st_nx      = RMW_WR;
      end
      RMW_WR: begin
        ram_a  = rmw_addr;
        ram_we = 1'b1;
        ram_wd = rmw_dat;
        st_nx  = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_rmw) begin
      rmw_addr <= ram_addr;
      rmw_dat  <= din;
      rmw_be   <= be;
    end else if (load_merge) begin
      rmw_dat  <= merged;
    end
  end

  // Read valid pipeline: bit k is high k cycles after an accepted read.
  logic [read_latency:1] vld_pipe;

  if (read_latency == 1) begin : g_pipe1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= acc_rd;
    end
  end else begin : g_pipe2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[read_latency-1:1], acc_rd};
    end
  end

  // dout_q keeps the last returned word so dout holds between strobes,
  // even though ram_q moves on every cycle (including RMW reads).
  logic [data_width-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dout_q <= '0;
    else if (vld_pipe[1]) dout_q <= ram_q;
  end

  if (read_latency == 1) begin : g_out1
    // ram_q is already the RAM's output register; present it on the
    // strobe cycle and fall back to the held copy afterwards.
    assign dout       = vld_pipe[1] ? ram_q : dout_q;
    assign dout_valid = vld_pipe[1];
  end else begin : g_out2
    assign dout       = dout_q;
    assign dout_valid = vld_pipe[read_latency];
  end

endmodule

// File: tb/tb_bram_window_rmw.sv
module tb_bram_window_rmw;

  localparam int BASE = 'h100;
  localparam int ENDA = 'h13F;
  localparam int LOGN = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        rd, wr;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout1, dout2;
  logic        dv1, dv2, hit1, hit2, busy1, busy2;

  always #5 clk = ~clk;

  bram_window_rmw #(
    .BaseAddress(BASE), .EndAddress(ENDA), .data_width(32), .lane_width(8),
    .address_width(16), .ram_size(64), .read_latency(1),
    .pre_fill(0), .pre_fill_start(0), .pre_fill_file("")
  ) u_l1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .be(be), .din(din),
    .dout(dout1), .dout_valid(dv1), .hit(hit1), .busy(busy1)
  );

  bram_window_rmw #(
    .BaseAddress(BASE), .EndAddress(ENDA), .data_width(32), .lane_width(8),
    .address_width(16), .ram_size(64), .read_latency(2),
    .pre_fill(0), .pre_fill_start(0), .pre_fill_file("")
  ) u_l2 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .be(be), .din(din),
    .dout(dout2), .dout_valid(dv2), .hit(hit2), .busy(busy2)
  );

  int cmp  = 0;
  int fail = 0;

  // Per-step log: hit sampled before the edge, the rest 1 ns after it.
  int          n = 0;
  bit          o_h1 [LOGN], o_h2 [LOGN], o_v1 [LOGN], o_v2 [LOGN], o_b1 [LOGN], o_b2 [LOGN];
  logic [31:0] o_d1 [LOGN], o_d2 [LOGN];
  bit          e_h  [LOGN], e_v1 [LOGN], e_v2 [LOGN], e_b  [LOGN];
  logic [31:0] e_d1 [LOGN], e_d2 [LOGN];

  // Reference model: memory by bus address, busy as a count of ignored
  // request slots, partial-write result committed when the slots expire.
  logic [31:0] mem [int];
  int          bcnt;
  bit          pend_ok;
  int          pend_a;
  logic [31:0] pend_d;
  bit          p2v;
  logic [31:0] p2d, l1, l2;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = b[i] ? d[i*8 +: 8] : o[i*8 +: 8];
    return m;
  endfunction

  function automatic void mdl_reset();
    bcnt = 0; pend_ok = 0; p2v = 0; p2d = '0; l1 = '0; l2 = '0;
  endfunction

  task automatic step(input bit r, input bit w, input int a, input logic [3:0] b, input logic [31:0] d);
    bit acc, rv;
    logic [31:0] rdat;
    rd = r; wr = w; addr = 16'(a); be = b; din = d;
    #1;
    o_h1[n] = hit1; o_h2[n] = hit2;
    e_h[n]  = (a >= BASE && a <= ENDA);
    acc = e_h[n] && (bcnt == 0);
    if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0 && pend_ok) begin mem[pend_a] = pend_d; pend_ok = 0; end
    end
    rv = 0; rdat = '0;
    if (acc && w) begin
      if (b == 4'hF) mem[a] = d;
      else if (b != 4'h0) begin pend_ok = 1; pend_a = a; pend_d = merge(mem[a], d, b); bcnt = 2; end
    end else if (acc && r) begin
      rv = 1; rdat = mem[a];
    end
    @(posedge clk); #1;
    o_v1[n] = dv1; o_d1[n] = dout1; o_v2[n] = dv2; o_d2[n] = dout2;
    o_b1[n] = busy1; o_b2[n] = busy2;
    if (rv) l1 = rdat;
    e_v1[n] = rv;  e_d1[n] = l1;
    if (p2v) l2 = p2d;
    e_v2[n] = p2v; e_d2[n] = l2;
    p2v = rv; p2d = rdat;
    e_b[n] = (bcnt > 0);
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd = 0; wr = 0; addr = '0; be = '0; din = '0;
    mdl_reset();
    #3;
    if (dout1 !== 32'h0) begin fail++; $display("FAIL reset_dout1: got %h want 0", dout1); end cmp++;
    if (dout2 !== 32'h0) begin fail++; $display("FAIL reset_dout2: got %h want 0", dout2); end cmp++;
    if ({dv1, dv2} !== 2'b00) begin fail++; $display("FAIL reset_valid: got %b want 00", {dv1, dv2}); end cmp++;
    if ({busy1, busy2} !== 2'b00) begin fail++; $display("FAIL reset_busy: got %b want 00", {busy1, busy2}); end cmp++;
    if ({hit1, hit2} !== 2'b00) begin fail++; $display("FAIL reset_hit_addr0: got %b want 00", {hit1, hit2}); end cmp++;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_preload();
    int s = n;
    for (int i = BASE; i <= ENDA; i++) step(0, 1, i, 4'hF, $urandom);
    for (int i = s; i < n; i++)
      if (o_b1[i] || o_b2[i]) begin fail++; $display("FAIL preload_busy: step %0d got 1 want 0", i); end
    cmp++;
  endtask

  task automatic test_full_write();
    int s = n, kr;
    step(0, 1, 'h105, 4'hF, 32'hDEADBEEF);
    step(1, 0, 'h105, 4'h0, 32'h0); kr = n - 1;
    idle(3);
    if (o_v1[kr-1] !== 1'b0) begin fail++; $display("FAIL fw_no_valid_on_wr: got %b want 0", o_v1[kr-1]); end cmp++;
    if (o_v1[kr] !== 1'b1 || o_d1[kr] !== 32'hDEADBEEF) begin fail++; $display("FAIL fw_lat1: got v=%b %h want v=1 deadbeef", o_v1[kr], o_d1[kr]); end cmp++;
    if (o_v2[kr] !== 1'b0) begin fail++; $display("FAIL fw_lat2_early: got %b want 0", o_v2[kr]); end cmp++;
    if (o_v2[kr+1] !== 1'b1 || o_d2[kr+1] !== 32'hDEADBEEF) begin fail++; $display("FAIL fw_lat2: got v=%b %h want v=1 deadbeef", o_v2[kr+1], o_d2[kr+1]); end cmp++;
    if (o_d1[kr+2] !== 32'hDEADBEEF) begin fail++; $display("FAIL fw_hold: got %h want deadbeef", o_d1[kr+2]); end cmp++;
    for (int i = s; i < n; i++)
      if (o_b1[i] || o_b2[i]) begin fail++; $display("FAIL fw_busy: step %0d got 1 want 0", i); end
    cmp++;
  endtask

  task automatic test_partial_and_busy();
    int k, kr;
    logic [31:0] old111;
    step(0, 1, 'h110, 4'hF, 32'h11223344);
    old111 = mem['h111];
    step(0, 1, 'h110, 4'b0101, 32'hAABBCCDD); k = n - 1;
    step(1, 0, 'h110, 4'h0, 32'h0);           // dropped: busy
    step(0, 1, 'h111, 4'hF, 32'hCAFEF00D);    // dropped: busy
    step(1, 0, 'h110, 4'h0, 32'h0); kr = n - 1;
    step(1, 0, 'h111, 4'h0, 32'h0);
    idle(2);
    if ({o_b1[k], o_b1[k+1], o_b1[k+2]} !== 3'b110) begin fail++; $display("FAIL rmw_busy_l1: got %b want 110", {o_b1[k], o_b1[k+1], o_b1[k+2]}); end cmp++;
    if ({o_b2[k], o_b2[k+1], o_b2[k+2]} !== 3'b110) begin fail++; $display("FAIL rmw_busy_l2: got %b want 110", {o_b2[k], o_b2[k+1], o_b2[k+2]}); end cmp++;
    if ({o_v1[k], o_v1[k+1], o_v1[k+2]} !== 3'b000) begin fail++; $display("FAIL rmw_valid_l1: got %b want 000", {o_v1[k], o_v1[k+1], o_v1[k+2]}); end cmp++;
    if ({o_v2[k+1], o_v2[k+2], o_v2[k+3]} !== 3'b000) begin fail++; $display("FAIL rmw_valid_l2: got %b want 000", {o_v2[k+1], o_v2[k+2], o_v2[k+3]}); end cmp++;
    if (o_v1[kr] !== 1'b1 || o_d1[kr] !== 32'h11BB33DD) begin fail++; $display("FAIL rmw_merge_l1: got v=%b %h want v=1 11bb33dd", o_v1[kr], o_d1[kr]); end cmp++;
    if (o_v2[kr+1] !== 1'b1 || o_d2[kr+1] !== 32'h11BB33DD) begin fail++; $display("FAIL rmw_merge_l2: got v=%b %h want v=1 11bb33dd", o_v2[kr+1], o_d2[kr+1]); end cmp++;
    if (o_d1[kr+1] !== old111) begin fail++; $display("FAIL busy_wr_dropped_l1: got %h want %h", o_d1[kr+1], old111); end cmp++;
    if (o_d2[kr+2] !== old111) begin fail++; $display("FAIL busy_wr_dropped_l2: got %h want %h", o_d2[kr+2], old111); end cmp++;
  endtask

  task automatic test_window_edges();
    int k0;
    logic [31:0] v100, v13f;
    v100 = mem['h100]; v13f = mem['h13F];
    k0 = n;
    step(1, 0, 'h0FF, 4'h0, 32'h0);
    step(1, 0, 'h140, 4'h0, 32'h0);
    step(0, 1, 'h140, 4'hF, 32'h5A5A5A5A);   // would alias onto 0x100 if decoded
    step(1, 0, 'h100, 4'h0, 32'h0);
    step(1, 0, 'h13F, 4'h0, 32'h0);
    idle(2);
    if ({o_h1[k0], o_h1[k0+1], o_h1[k0+2], o_h1[k0+3], o_h1[k0+4]} !== 5'b00011) begin fail++; $display("FAIL win_hit_l1: got %b want 00011", {o_h1[k0], o_h1[k0+1], o_h1[k0+2], o_h1[k0+3], o_h1[k0+4]}); end cmp++;
    if ({o_h2[k0], o_h2[k0+1], o_h2[k0+2], o_h2[k0+3], o_h2[k0+4]} !== 5'b00011) begin fail++; $display("FAIL win_hit_l2: got %b want 00011", {o_h2[k0], o_h2[k0+1], o_h2[k0+2], o_h2[k0+3], o_h2[k0+4]}); end cmp++;
    if ({o_v1[k0], o_v1[k0+1], o_v1[k0+2]} !== 3'b000) begin fail++; $display("FAIL win_out_valid_l1: got %b want 000", {o_v1[k0], o_v1[k0+1], o_v1[k0+2]}); end cmp++;
    if ({o_v2[k0+1], o_v2[k0+2], o_v2[k0+3]} !== 3'b000) begin fail++; $display("FAIL win_out_valid_l2: got %b want 000", {o_v2[k0+1], o_v2[k0+2], o_v2[k0+3]}); end cmp++;
    if (o_v1[k0+3] !== 1'b1 || o_d1[k0+3] !== v100) begin fail++; $display("FAIL win_base_l1: got v=%b %h want v=1 %h", o_v1[k0+3], o_d1[k0+3], v100); end cmp++;
    if (o_v1[k0+4] !== 1'b1 || o_d1[k0+4] !== v13f) begin fail++; $display("FAIL win_end_l1: got v=%b %h want v=1 %h", o_v1[k0+4], o_d1[k0+4], v13f); end cmp++;
    if (o_v2[k0+5] !== 1'b1 || o_d2[k0+5] !== v13f) begin fail++; $display("FAIL win_end_l2: got v=%b %h want v=1 %h", o_v2[k0+5], o_d2[k0+5], v13f); end cmp++;
  endtask

  task automatic test_rdwr_and_reset();
    int k, kr, kp;
    step(1, 1, 'h120, 4'hF, 32'h0BADCAFE); k = n - 1;
    idle(1);
    step(1, 0, 'h120, 4'h0, 32'h0); kr = n - 1;
    idle(1);
    if (o_v1[k] !== 1'b0 || o_v2[k+1] !== 1'b0) begin fail++; $display("FAIL rdwr_no_valid: got %b%b want 00", o_v1[k], o_v2[k+1]); end cmp++;
    if (o_d1[kr] !== 32'h0BADCAFE) begin fail++; $display("FAIL rdwr_wr_wins: got %h want 0badcafe", o_d1[kr]); end cmp++;
    step(0, 1, 'h120, 4'b0011, 32'hFFFFFFFF); kp = n - 1;   // now in the read phase of the RMW
    if (o_b1[kp] !== 1'b1) begin fail++; $display("FAIL rst_pre_busy: got %b want 1", o_b1[kp]); end cmp++;
    rd = 0; wr = 0; rst_n = 1'b0;
    mdl_reset();
    #1;
    if ({busy1, busy2} !== 2'b00) begin fail++; $display("FAIL rst_mid_busy: got %b want 00", {busy1, busy2}); end cmp++;
    if (dout1 !== 32'h0 || dout2 !== 32'h0) begin fail++; $display("FAIL rst_mid_dout: got %h %h want 0 0", dout1, dout2); end cmp++;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 'h120, 4'h0, 32'h0); kr = n - 1;
    idle(2);
    if (o_d1[kr] !== 32'h0BADCAFE) begin fail++; $display("FAIL rst_discard_l1: got %h want 0badcafe", o_d1[kr]); end cmp++;
    if (o_d2[kr+1] !== 32'h0BADCAFE) begin fail++; $display("FAIL rst_discard_l2: got %h want 0badcafe", o_d2[kr+1]); end cmp++;
  endtask

  task automatic test_back_to_back();
    int s;
    logic [31:0] exp_w [8];
    for (int i = 0; i < 8; i++) exp_w[i] = mem[BASE + i];
    s = n;
    for (int i = 0; i < 8; i++) step(1, 0, BASE + i, 4'h0, 32'h0);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      if (o_v1[s+i] !== 1'b1 || o_d1[s+i] !== exp_w[i]) begin fail++; $display("FAIL stream_l1[%0d]: got v=%b %h want v=1 %h", i, o_v1[s+i], o_d1[s+i], exp_w[i]); end cmp++;
      if (o_v2[s+i+1] !== 1'b1 || o_d2[s+i+1] !== exp_w[i]) begin fail++; $display("FAIL stream_l2[%0d]: got v=%b %h want v=1 %h", i, o_v2[s+i+1], o_d2[s+i+1], exp_w[i]); end cmp++;
    end
    if (o_v2[s] !== 1'b0 || o_v1[s+8] !== 1'b0 || o_v2[s+9] !== 1'b0) begin fail++; $display("FAIL stream_edges: got %b%b%b want 000", o_v2[s], o_v1[s+8], o_v2[s+9]); end cmp++;
  endtask

  task automatic test_random();
    int s = n;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] b;
      b = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      step(1'($urandom), ($urandom_range(0, 2) == 0), 'hF8 + $urandom_range(0, 'h4F), b, $urandom);
    end
    idle(3);
    for (int i = s; i < n; i++) begin
      if (o_h1[i] !== e_h[i])  begin fail++; $display("FAIL rnd_hit1 step %0d: got %b want %b", i, o_h1[i], e_h[i]); end cmp++;
      if (o_h2[i] !== e_h[i])  begin fail++; $display("FAIL rnd_hit2 step %0d: got %b want %b", i, o_h2[i], e_h[i]); end cmp++;
      if (o_v1[i] !== e_v1[i]) begin fail++; $display("FAIL rnd_valid1 step %0d: got %b want %b", i, o_v1[i], e_v1[i]); end cmp++;
      if (o_v2[i] !== e_v2[i]) begin fail++; $display("FAIL rnd_valid2 step %0d: got %b want %b", i, o_v2[i], e_v2[i]); end cmp++;
      if (o_d1[i] !== e_d1[i]) begin fail++; $display("FAIL rnd_dout1 step %0d: got %h want %h", i, o_d1[i], e_d1[i]); end cmp++;
      if (o_d2[i] !== e_d2[i]) begin fail++; $display("FAIL rnd_dout2 step %0d: got %h want %h", i, o_d2[i], e_d2[i]); end cmp++;
      if (o_b1[i] !== e_b[i])  begin fail++; $display("FAIL rnd_busy1 step %0d: got %b want %b", i, o_b1[i], e_b[i]); end cmp++;
      if (o_b2[i] !== e_b[i])  begin fail++; $display("FAIL rnd_busy2 step %0d: got %b want %b", i, o_b2[i], e_b[i]); end cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_full_write();
    test_partial_and_busy();
    test_window_edges();
    test_rdwr_and_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
    $finish;
  end

endmodule
